// File: rtl/stepper_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : stepper_sequencer
// Brief   : Four-coil stepper sequencer driven by a synchronised step clock.
// Revision: 1.0 - initial release
// ============================================================================
module stepper_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_clk,
  input  logic             en,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             start,
  input  logic [CNT_W-1:0] num_steps,
  output logic             busy,
  output logic             done,
  output logic [3:0]       coils,
  output logic [CNT_W-1:0] position
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] C_MODE_FULL = 2'b01;
  localparam logic [1:0] C_MODE_HALF = 2'b10;

  state_t           state_q, state_d;
  logic [2:0]       sync_q;
  logic             tick;
  logic [2:0]       phase_q, phase_d;
  logic [2:0]       step_w;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0] position_q, position_d;
  logic             dir_q, dir_d;
  logic [1:0]       mode_q, mode_d;
  logic             done_q;
  logic [3:0]       coils_q;

  function automatic logic [3:0] phase_coils(input logic [2:0] p);
    logic [3:0] c;
    case (p)
      3'd0:    c = 4'b1000;
      3'd1:    c = 4'b1100;
      3'd2:    c = 4'b0100;
      3'd3:    c = 4'b0110;
      3'd4:    c = 4'b0010;
      3'd5:    c = 4'b0011;
      3'd6:    c = 4'b0001;
      default: c = 4'b1001;
    endcase
    return c;
  endfunction

  // sync_q[1:0] is the two-flop synchroniser, sync_q[2] the edge-detect delay.
  assign tick   = sync_q[1] & ~sync_q[2];
  assign step_w = (mode_q == C_MODE_HALF) ? 3'd1 : 3'd2;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    remaining_d = remaining_q;
    position_d  = position_q;
    dir_d       = dir_q;
    mode_d      = mode_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          dir_d       = dir;
          mode_d      = mode;
          remaining_d = num_steps;
          if (mode == C_MODE_FULL)      phase_d = phase_q | 3'b001;
          else if (mode != C_MODE_HALF) phase_d = phase_q & 3'b110;
          state_d = (num_steps == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (tick && en) begin
          phase_d     = dir_q ? (phase_q + step_w) : (phase_q - step_w);
          remaining_d = remaining_q - CNT_W'(1);
          position_d  = dir_q ? (position_q + CNT_W'(1)) : (position_q - CNT_W'(1));
          if (remaining_q == CNT_W'(1)) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      sync_q      <= 3'b000;
      phase_q     <= 3'd0;
      remaining_q <= '0;
      position_q  <= '0;
      dir_q       <= 1'b0;
      mode_q      <= 2'b00;
      done_q      <= 1'b0;
      coils_q     <= 4'b0000;
    end else begin
      state_q     <= state_d;
      sync_q      <= {sync_q[1:0], step_clk};
      phase_q     <= phase_d;
      remaining_q <= remaining_d;
      position_q  <= position_d;
      dir_q       <= dir_d;
      mode_q      <= mode_d;
      done_q      <= (state_q == S_DONE);
      coils_q     <= en ? phase_coils(phase_q) : 4'b0000;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign coils    = coils_q;
  assign position = position_q;

endmodule
`default_nettype wire

// File: tb/tb_stepper_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_stepper_sequencer
// Brief   : Directed self-checking bench for stepper_sequencer.
// Revision: 1.0 - initial release
// ============================================================================
module tb_stepper_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        step_clk = 1'b0;
  logic        en = 1'b0;
  logic        dir = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        start = 1'b0;
  logic [15:0] num_steps = 16'd0;
  logic        busy, done;
  logic [3:0]  coils;
  logic [15:0] position;

  logic        start2 = 1'b0;
  logic [3:0]  num2 = 4'd0;
  logic        busy2, done2;
  logic [3:0]  coils2;
  logic [3:0]  pos2;

  int n_cmp  = 0;
  int n_fail = 0;
  int done_cnt  = 0;
  int done2_cnt = 0;
  int snap;

  stepper_sequencer #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .step_clk(step_clk), .en(en), .dir(dir), .mode(mode),
    .start(start), .num_steps(num_steps), .busy(busy), .done(done),
    .coils(coils), .position(position)
  );

  stepper_sequencer #(.CNT_W(4)) dut_w4 (
    .clk(clk), .rst(rst), .step_clk(step_clk), .en(en), .dir(dir), .mode(mode),
    .start(start2), .num_steps(num2), .busy(busy2), .done(done2),
    .coils(coils2), .position(pos2)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done)  done_cnt  <= done_cnt + 1;
    if (done2) done2_cnt <= done2_cnt + 1;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic step_pulse();
    step_clk = 1'b1;
    tick_clk(4);
    step_clk = 1'b0;
    tick_clk(4);
  endtask

  task automatic do_start(input logic d, input logic [1:0] m, input logic [15:0] n);
    dir = d; mode = m; num_steps = n; start = 1'b1;
    tick_clk(1);
    start = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    tick_clk(2);
    rst = 1'b1;
    tick_clk(2);
  endtask

  task automatic test_reset();
    logic [3:0] exp_half [3];
    exp_half[0] = 4'b1100; exp_half[1] = 4'b0100; exp_half[2] = 4'b0110;
    tick_clk(3);
    n_cmp++; if (coils !== 4'b0000) begin n_fail++; $display("FAIL reset_coils: got %b want 0000", coils); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (position !== 16'h0000) begin n_fail++; $display("FAIL reset_pos: got %h want 0000", position); end
    rst = 1'b1; en = 1'b1;
    tick_clk(2);
    do_start(1'b1, 2'b10, 16'd8);
    for (int i = 0; i < 3; i++) begin
      step_pulse();
      n_cmp++; if (coils !== exp_half[i]) begin n_fail++; $display("FAIL reset_pre_coils[%0d]: got %b want %b", i, coils, exp_half[i]); end
    end
    snap = done_cnt;
    rst = 1'b0;
    #2;
    n_cmp++; if (coils !== 4'b0000) begin n_fail++; $display("FAIL reset_mid_coils: got %b want 0000", coils); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid_busy: got %b want 0", busy); end
    n_cmp++; if (position !== 16'h0000) begin n_fail++; $display("FAIL reset_mid_pos: got %h want 0000", position); end
    tick_clk(1);
    rst = 1'b1;
    tick_clk(1);
    n_cmp++; if (coils !== 4'b1000) begin n_fail++; $display("FAIL reset_release_coils: got %b want 1000", coils); end
    tick_clk(3);
    n_cmp++; if (done_cnt !== snap) begin n_fail++; $display("FAIL reset_no_done: got %0d pulses want 0", done_cnt - snap); end
  endtask

  task automatic test_half_fwd();
    logic [3:0] exp_c [8];
    exp_c[0] = 4'b1100; exp_c[1] = 4'b0100; exp_c[2] = 4'b0110; exp_c[3] = 4'b0010;
    exp_c[4] = 4'b0011; exp_c[5] = 4'b0001; exp_c[6] = 4'b1001; exp_c[7] = 4'b1000;
    apply_reset();
    snap = done_cnt;
    do_start(1'b1, 2'b10, 16'd8);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL half_busy_rise: got %b want 1", busy); end
    for (int i = 0; i < 8; i++) begin
      step_pulse();
      n_cmp++; if (coils !== exp_c[i]) begin n_fail++; $display("FAIL half_coils[%0d]: got %b want %b", i, coils, exp_c[i]); end
    end
    n_cmp++; if (position !== 16'd8) begin n_fail++; $display("FAIL half_pos: got %h want 0008", position); end
    n_cmp++; if (done_cnt - snap !== 1) begin n_fail++; $display("FAIL half_done_count: got %0d want 1", done_cnt - snap); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL half_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_full_rev();
    logic [3:0] exp_c [3];
    exp_c[0] = 4'b1001; exp_c[1] = 4'b0011; exp_c[2] = 4'b0110;
    apply_reset();
    snap = done_cnt;
    do_start(1'b0, 2'b01, 16'd3);
    tick_clk(2);
    n_cmp++; if (coils !== 4'b1100) begin n_fail++; $display("FAIL full_align: got %b want 1100", coils); end
    for (int i = 0; i < 3; i++) begin
      step_pulse();
      n_cmp++; if (coils !== exp_c[i]) begin n_fail++; $display("FAIL full_coils[%0d]: got %b want %b", i, coils, exp_c[i]); end
    end
    n_cmp++; if (position !== 16'hFFFD) begin n_fail++; $display("FAIL full_pos: got %h want fffd", position); end
    n_cmp++; if (done_cnt - snap !== 1) begin n_fail++; $display("FAIL full_done_count: got %0d want 1", done_cnt - snap); end
  endtask

  task automatic test_pause();
    apply_reset();
    snap = done_cnt;
    do_start(1'b1, 2'b00, 16'd4);
    step_pulse();
    n_cmp++; if (coils !== 4'b0100) begin n_fail++; $display("FAIL pause_step1: got %b want 0100", coils); end
    step_pulse();
    n_cmp++; if (coils !== 4'b0010) begin n_fail++; $display("FAIL pause_step2: got %b want 0010", coils); end
    en = 1'b0;
    tick_clk(2);
    n_cmp++; if (coils !== 4'b0000) begin n_fail++; $display("FAIL pause_release: got %b want 0000", coils); end
    for (int i = 0; i < 3; i++) begin
      step_pulse();
      n_cmp++; if (coils !== 4'b0000) begin n_fail++; $display("FAIL pause_coils[%0d]: got %b want 0000", i, coils); end
    end
    n_cmp++; if (position !== 16'd2) begin n_fail++; $display("FAIL pause_pos_hold: got %h want 0002", position); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL pause_busy: got %b want 1", busy); end
    en = 1'b1;
    tick_clk(2);
    n_cmp++; if (coils !== 4'b0010) begin n_fail++; $display("FAIL pause_resume: got %b want 0010", coils); end
    step_pulse();
    n_cmp++; if (coils !== 4'b0001) begin n_fail++; $display("FAIL pause_step3: got %b want 0001", coils); end
    step_pulse();
    n_cmp++; if (coils !== 4'b1000) begin n_fail++; $display("FAIL pause_step4: got %b want 1000", coils); end
    n_cmp++; if (position !== 16'd4) begin n_fail++; $display("FAIL pause_pos: got %h want 0004", position); end
    n_cmp++; if (done_cnt - snap !== 1) begin n_fail++; $display("FAIL pause_done_count: got %0d want 1", done_cnt - snap); end
  endtask

  task automatic test_boundaries();
    // Zero-length move: busy for one cycle, then done; phase 0 is already even.
    do_start(1'b1, 2'b11, 16'd0);
    n_cmp++; if ({busy, done} !== 2'b10) begin n_fail++; $display("FAIL zero_cyc1 busy,done: got %b want 10", {busy, done}); end
    tick_clk(1);
    n_cmp++; if ({busy, done} !== 2'b01) begin n_fail++; $display("FAIL zero_cyc2 busy,done: got %b want 01", {busy, done}); end
    tick_clk(1);
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL zero_done_len: got %b want 0", done); end
    n_cmp++; if (coils !== 4'b1000) begin n_fail++; $display("FAIL zero_coils: got %b want 1000", coils); end
    do_start(1'b1, 2'b10, 16'd2);
    tick_clk(2);
    do_start(1'b1, 2'b10, 16'd5);
    step_pulse();
    step_pulse();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_start_busy: got %b want 0", busy); end
    n_cmp++; if (position !== 16'd6) begin n_fail++; $display("FAIL busy_start_pos: got %h want 0006", position); end
    step_pulse();
    n_cmp++; if (position !== 16'd6) begin n_fail++; $display("FAIL idle_tick_pos: got %h want 0006", position); end
    n_cmp++; if (coils !== 4'b0100) begin n_fail++; $display("FAIL idle_tick_coils: got %b want 0100", coils); end
    // Raise step_clk so its tick lands on the same edge that samples start.
    step_clk = 1'b1;
    tick_clk(2);
    dir = 1'b1; mode = 2'b10; num_steps = 16'd1; start = 1'b1;
    tick_clk(1);
    start = 1'b0;
    tick_clk(2);
    step_clk = 1'b0;
    tick_clk(4);
    n_cmp++; if (position !== 16'd6) begin n_fail++; $display("FAIL coinc_tick_pos: got %h want 0006", position); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL coinc_tick_busy: got %b want 1", busy); end
    step_pulse();
    n_cmp++; if (position !== 16'd7) begin n_fail++; $display("FAIL coinc_next_pos: got %h want 0007", position); end
    n_cmp++; if (coils !== 4'b0110) begin n_fail++; $display("FAIL coinc_next_coils: got %b want 0110", coils); end
  endtask

  task automatic test_wrap();
    snap = done2_cnt;
    dir = 1'b1; mode = 2'b10; num2 = 4'd7; start2 = 1'b1;
    tick_clk(1);
    start2 = 1'b0;
    for (int i = 0; i < 7; i++) step_pulse();
    n_cmp++; if (pos2 !== 4'h7) begin n_fail++; $display("FAIL wrap_pre: got %h want 7", pos2); end
    num2 = 4'd1; start2 = 1'b1;
    tick_clk(1);
    start2 = 1'b0;
    step_pulse();
    n_cmp++; if (pos2 !== 4'h8) begin n_fail++; $display("FAIL wrap_post: got %h want 8", pos2); end
    n_cmp++; if (done2_cnt - snap !== 2) begin n_fail++; $display("FAIL wrap_done_count: got %0d want 2", done2_cnt - snap); end
    n_cmp++; if (position !== 16'd7) begin n_fail++; $display("FAIL wrap_main_idle: got %h want 0007", position); end
  endtask

  initial begin
    test_reset();
    test_half_fwd();
    test_full_rev();
    test_pause();
    test_boundaries();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
